matrix_ctrl: RTL and testbench

MATRIX_CTRL -- requirements
Module: matrix_ctrl

---
 rtl/matrix_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_matrix_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_ctrl.sv
// rtl/matrix_ctrl.sv - battleship-style 5x7 LED matrix game controller
// Optional cursor blink overlay enabled by defining BLINK_CURSOR_EN.
module matrix_ctrl #(
   parameter int SCAN_DIV  = 50000,
   parameter int MAX_SHIPS = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ch7,
   input  logic       ch6,
   input  logic       ca,
   input  logic       cb,
   input  logic       cc,
   input  logic       cd,
   input  logic       ce,
   input  logic [2:0] row,
   input  logic       btn,
   output logic [4:0] col_out,
   output logic [6:0] row_out,
   output logic       hit,
   output logic       miss,
   output logic [2:0] ships_left,
   output logic       game_over
);

   localparam int            CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [2:0]    MAX_CNT = 3'(MAX_SHIPS);

   typedef enum logic [1:0] {IDLE, PLACE, ATTACK, OVER} state_t;

   state_t          state, state_nx;
   logic [4:0][6:0] ship_map, shot_map;
   logic [2:0]      ship_count;
   logic            btn_q;
   logic [CW-1:0]   scan_cnt;
   logic [2:0]      col_idx;
   logic [4:0]      sel;
   logic [2:0]      sel_col;
   logic            sel_ok;
   logic            confirm;

   assign sel = {ce, cd, cc, cb, ca};

   always_comb begin
      sel_col = 3'd0;
      sel_ok  = 1'b0;
      case (sel)
         5'b00001: begin sel_col = 3'd0; sel_ok = 1'b1; end
         5'b00010: begin sel_col = 3'd1; sel_ok = 1'b1; end
         5'b00100: begin sel_col = 3'd2; sel_ok = 1'b1; end
         5'b01000: begin sel_col = 3'd3; sel_ok = 1'b1; end
         5'b10000: begin sel_col = 3'd4; sel_ok = 1'b1; end
         default:  ;
      endcase
      if (row == 3'd7) sel_ok = 1'b0;
   end

   assign confirm = btn & ~btn_q & sel_ok;

   always_comb begin
      state_nx = state;
      if (!ch7) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    state_nx = PLACE;
            PLACE:   if (ch6 && ship_count != 3'd0) state_nx = ATTACK;
            ATTACK:  if (ships_left == 3'd0) state_nx = OVER;
            OVER:    state_nx = OVER;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Game-off clears everything and suppresses any confirm arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ship_map   <= '0;
         shot_map   <= '0;
         ship_count <= 3'd0;
         ships_left <= 3'd0;
         btn_q      <= 1'b0;
         hit        <= 1'b0;
         miss       <= 1'b0;
      end else begin
         btn_q <= btn;
         hit   <= 1'b0;
         miss  <= 1'b0;
         if (!ch7) begin
            ship_map   <= '0;
            shot_map   <= '0;
            ship_count <= 3'd0;
            ships_left <= 3'd0;
         end else begin
            case (state)
               PLACE: begin
                  if (confirm) begin
                     if (ship_map[sel_col][row]) begin
                        ship_map[sel_col][row] <= 1'b0;
                        ship_count             <= ship_count - 3'd1;
                     end else if (ship_count < MAX_CNT) begin
                        ship_map[sel_col][row] <= 1'b1;
                        ship_count             <= ship_count + 3'd1;
                     end
                  end
                  if (state_nx == ATTACK) ships_left <= ship_count;
               end
               ATTACK: begin
                  if (confirm && !shot_map[sel_col][row]) begin
                     shot_map[sel_col][row] <= 1'b1;
                     if (ship_map[sel_col][row]) begin
                        hit        <= 1'b1;
                        ships_left <= ships_left - 3'd1;
                     end else begin
                        miss <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || state == IDLE) begin
         scan_cnt <= '0;
         col_idx  <= 3'd0;
      end else if (scan_cnt == CNT_MAX) begin
         scan_cnt <= '0;
         col_idx  <= (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

`ifdef BLINK_CURSOR_EN
   logic [3:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         frame_cnt <= 4'd0;
      else if (state != IDLE && scan_cnt == CNT_MAX && col_idx == 3'd4)
         frame_cnt <= frame_cnt + 4'd1;
   end
`endif

   always_comb begin
      col_out = 5'd0;
      row_out = 7'd0;
      case (state)
         PLACE: begin
            col_out = 5'd1 << col_idx;
            row_out = ship_map[col_idx];
         end
         ATTACK: begin
            col_out = 5'd1 << col_idx;
            row_out = ship_map[col_idx] & shot_map[col_idx];
         end
         OVER: begin
            col_out = 5'd1 << col_idx;
            row_out = ship_map[col_idx];
         end
         default: ;
      endcase
`ifdef BLINK_CURSOR_EN
      if ((state == PLACE || state == ATTACK) && sel_ok && sel_col == col_idx)
         row_out[row] = row_out[row] ^ frame_cnt[3];
`endif
   end

   assign game_over = (state == OVER);

endmodule

// File: tb/tb_matrix_ctrl.sv
// tb/tb_matrix_ctrl.sv - randomized self-checking bench for matrix_ctrl
module tb_matrix_ctrl;

   localparam int SD = 4;
   localparam int MS = 5;

   logic       clk = 1'b0;
   logic       rst, ch7, ch6, ca, cb, cc, cd, ce, btn;
   logic [2:0] row;
   logic [4:0] col_out;
   logic [6:0] row_out;
   logic       hit, miss, game_over;
   logic [2:0] ships_left;

   matrix_ctrl #(.SCAN_DIV(SD), .MAX_SHIPS(MS)) dut (
      .clk(clk), .rst(rst), .ch7(ch7), .ch6(ch6),
      .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce),
      .row(row), .btn(btn),
      .col_out(col_out), .row_out(row_out),
      .hit(hit), .miss(miss), .ships_left(ships_left), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // reference game: phase 0 off, 1 placing, 2 attacking, 3 over
   bit m_ship[5][7];
   bit m_shot[5][7];
   int m_cnt, m_left, m_phase, scan_k;
   bit m_btn_q, e_hit, e_miss;
   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < 5; c++)
         for (int r = 0; r < 7; r++) begin
            m_ship[c][r] = 0;
            m_shot[c][r] = 0;
         end
      m_cnt = 0; m_left = 0; m_phase = 0;
   endtask

   task automatic check_outputs();
      logic [4:0] ec = '0;
      logic [6:0] er = '0;
      int col;
      if (m_phase != 0) begin
         col = (scan_k / SD) % 5;
         ec  = 5'(1 << col);
         for (int r = 0; r < 7; r++)
            er[r] = (m_phase == 2) ? (m_ship[col][r] & m_shot[col][r]) : m_ship[col][r];
      end
      check_val("col_out", col_out, ec);
      check_val("row_out", row_out, er);
      check_val("hit", hit, e_hit);
      check_val("miss", miss, e_miss);
      check_val("ships_left", ships_left, m_left);
      check_val("game_over", game_over, m_phase == 3);
   endtask

   task automatic step();
      logic [4:0] s = {ce, cd, cc, cb, ca};
      bit confirm = btn && !m_btn_q;
      bit valid = ($countones(s) == 1) && (row != 3'd7);
      int c = 0;
      int old = m_phase;
      for (int i = 0; i < 5; i++) if (s[i]) c = i;
      e_hit = 0; e_miss = 0;
      if (rst) begin
         clear_model();
         m_btn_q = 0;
      end else begin
         if (!ch7) clear_model();
         else if (m_phase == 0) m_phase = 1;
         else if (m_phase == 1) begin
            int cnt0 = m_cnt;
            if (confirm && valid) begin
               if (m_ship[c][row]) begin m_ship[c][row] = 0; m_cnt--; end
               else if (m_cnt < MS) begin m_ship[c][row] = 1; m_cnt++; end
            end
            if (ch6 && cnt0 >= 1) begin m_phase = 2; m_left = cnt0; end
         end else if (m_phase == 2) begin
            int left0 = m_left;
            if (confirm && valid && !m_shot[c][row]) begin
               m_shot[c][row] = 1;
               if (m_ship[c][row]) begin e_hit = 1; m_left--; end
               else e_miss = 1;
            end
            if (left0 == 0) m_phase = 3;
         end
         m_btn_q = btn;
      end
      scan_k = (rst || old == 0) ? 0 : scan_k + 1;
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic press(input logic [4:0] s, input logic [2:0] r);
      {ce, cd, cc, cb, ca} = s;
      row = r;
      btn = 1'b1;
      step();
      btn = 1'b0;
      step();
   endtask

   task automatic rand_press(input int bias_ships);
      logic [4:0] s = 5'(1 << $urandom_range(0, 4));
      logic [2:0] r = 3'($urandom_range(0, 6));
      int pick = $urandom_range(0, 9);
      if (pick == 0) s = s | 5'(1 << $urandom_range(0, 4));
      else if (pick == 1) r = 3'd7;
      else if (bias_ships != 0 && pick > 4) begin
         int q[$];
         for (int i = 0; i < 35; i++)
            if (m_ship[i / 7][i % 7] && !m_shot[i / 7][i % 7]) q.push_back(i);
         if (q.size() > 0) begin
            int k = q[$urandom_range(0, q.size() - 1)];
            s = 5'(1 << (k / 7));
            r = 3'(k % 7);
         end
      end
      press(s, r);
   endtask

   task automatic random_game(input bit do_reset);
      ch7 = 1'b1; ch6 = 1'b0;
      step();
      repeat ($urandom_range(1, 10)) rand_press(0);
      if (m_cnt == 0) press(5'b00001, 3'd0);
      ch6 = 1'b1; step(); step();
      if (do_reset) begin
         ch6 = $urandom_range(0, 1);
         {ce, cd, cc, cb, ca} = 5'b00001; row = 3'd0;
         btn = 1'b1; rst = 1'b1;
         step();
         rst = 1'b0; btn = 1'b0;
         step(); step();
      end else begin
         for (int i = 0; i < 300 && m_phase == 2; i++) begin
            ch6 = $urandom_range(0, 1);
            rand_press(1);
         end
         step();
         check_val("game_over_end", game_over, 1);
      end
      ch7 = 1'b0; ch6 = 1'b0;
      step(); step();
   endtask

   initial begin
      clear_model();
      m_btn_q = 0; scan_k = 0; e_hit = 0; e_miss = 0;
      rst = 1'b1; ch7 = 1'b0; ch6 = 1'b0; btn = 1'b0;
      {ce, cd, cc, cb, ca} = 5'b00000; row = 3'd0;
      repeat (3) step();
      rst = 1'b0; ch7 = 1'b1;
      repeat (25) step();

      press(5'b00001, 3'd2);
      repeat (4) step();
      press(5'b00001, 3'd2);
      ch6 = 1'b1; repeat (3) step(); ch6 = 1'b0;
      press(5'b00010, 3'd1);
      press(5'b00010, 3'd1);

      press(5'b00001, 3'd0);
      press(5'b00010, 3'd1);
      press(5'b00100, 3'd2);
      press(5'b01000, 3'd3);
      press(5'b10000, 3'd4);
      press(5'b10000, 3'd6);
      press(5'b00110, 3'd1);
      press(5'b00001, 3'd7);
      repeat (20) step();
      ch6 = 1'b1; step(); ch6 = 1'b0; step();
      check_val("ships_left_start", ships_left, 5);

      press(5'b00001, 3'd0);
      check_val("ships_left_after_hit", ships_left, 4);
      press(5'b00001, 3'd0);
      press(5'b00001, 3'd1);
      press(5'b00110, 3'd2);
      press(5'b00100, 3'd7);
      press(5'b00010, 3'd1);
      press(5'b00100, 3'd2);
      press(5'b01000, 3'd3);
      press(5'b10000, 3'd4);
      repeat (22) step();
      check_val("game_over_dir", game_over, 1);

      {ce, cd, cc, cb, ca} = 5'b00001; row = 3'd0;
      ch7 = 1'b0; btn = 1'b1;
      step();
      btn = 1'b0;
      step(); step();
      ch7 = 1'b1;
      repeat (22) step();
      ch7 = 1'b0; step(); step();

      for (int g = 0; g < 6; g++) random_game(g == 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout checks %0d", checks);
      $fatal(1, "timeout");
   end

endmodule
